// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the instruction-memory boot loader.
//   loader_state_t : loader FSM states
//   ERR_*          : err_code values reported by the loader
//   word_byte_addr : byte address of word <index> in an image placed at <base>
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    // Instruction words are 4 bytes apart.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/imem_addr_gen.sv
// imem_addr_gen
// Word counter shared by the write (LOAD) and read-back (VERIFY) phases.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   clear       : reset the count to zero (takes priority over inc)
//   inc         : advance to the next word
//   count       : current word index
//   addr        : BASE_ADDR + 4*count
module imem_addr_gen
    import cpu_pkg::*;
#(
    parameter int          CNT_W     = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      addr
);

    // Word index register; clear wins so a phase change can restart at word 0
    // on the same edge that would otherwise have advanced the count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    always_comb begin
        addr = word_byte_addr(BASE_ADDR, 32'(count));
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time loader in front of the CPU core. Streams an image into
// instruction memory, reads it back, compares an XOR checksum and only then
// releases the core through cpu_enable.
// Ports:
//   clk, arst_n          : clock, asynchronous active-low reset
//   start, halt          : single-cycle control pulses (halt wins over start)
//   s_valid/s_data/s_last/s_ready : host word stream
//   addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext : instruction-memory port,
//                          rdata_ext valid one cycle after ren_ext
//   cpu_enable           : core enable, high only in RUN
//   busy / error         : in LOAD or VERIFY / in ERROR
//   err_code             : ERR_NONE, ERR_OVF or ERR_CSUM
//   word_count, checksum : words accepted and their XOR for the current load
// Every output is a register; the comb blocks below compute the value each
// output takes after the next edge.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       start,
    input  logic                       halt,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [31:0]                addr_ext,
    output logic                       wen_ext,
    output logic                       ren_ext,
    output logic [DATA_W-1:0]          wdata_ext,
    input  logic [DATA_W-1:0]          rdata_ext,
    output logic                       cpu_enable,
    output logic                       busy,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH):0]     word_count,
    output logic [DATA_W-1:0]          checksum
);

    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    loader_state_t state;
    loader_state_t next_state;

    logic [CNT_W-1:0]  gen_count;
    logic [31:0]       gen_addr;
    logic              gen_clear;
    logic              gen_inc;

    logic              hs;
    logic              rd_issue;
    logic              verify_done;
    logic              entering_load;

    logic [DATA_W-1:0] verify_acc;
    logic              sample_pending;

    logic              s_ready_d;
    logic [31:0]       addr_d;
    logic              wen_d;
    logic              ren_d;
    logic [DATA_W-1:0] wdata_d;
    logic              cpu_enable_d;
    logic              busy_d;
    logic              error_d;
    logic [1:0]        err_code_d;
    logic [CNT_W-1:0]  word_count_d;
    logic [DATA_W-1:0] checksum_d;
    logic [DATA_W-1:0] verify_acc_d;
    logic              sample_pending_d;

    // halt cancels a handshake or read that would otherwise be registered.
    assign hs            = (state == ST_LOAD) && s_valid && s_ready && !halt;
    assign rd_issue      = (state == ST_VERIFY) && !halt && (gen_count < word_count);
    // All reads issued, last read returned and folded in: compare next.
    assign verify_done   = (state == ST_VERIFY) && (gen_count == word_count)
                           && !ren_ext && !sample_pending;
    assign entering_load = (next_state == ST_LOAD) && (state != ST_LOAD);

    // The counter tracks the write index during LOAD, restarts at the final
    // handshake and then tracks the read index during VERIFY.
    assign gen_clear = entering_load || (next_state == ST_IDLE) || (hs && s_last);
    assign gen_inc   = hs || rd_issue;

    imem_addr_gen #(
        .CNT_W     (CNT_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (gen_clear),
        .inc    (gen_inc),
        .count  (gen_count),
        .addr   (gen_addr)
    );

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A full buffer without s_last spends one cycle in
    // LOAD (issuing the last write) before moving to ERROR.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start && !halt) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (halt)                          next_state = ST_IDLE;
                else if (hs && s_last)             next_state = ST_VERIFY;
                else if (word_count == DEPTH_CNT)  next_state = ST_ERROR;
            end
            ST_VERIFY: begin
                if (halt)             next_state = ST_IDLE;
                else if (verify_done) next_state = (verify_acc == checksum) ? ST_RUN : ST_ERROR;
            end
            ST_RUN: begin
                if (halt) next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (start && !halt) next_state = ST_LOAD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of all registered outputs and datapath state.
    always_comb begin
        wen_d            = hs;
        ren_d            = rd_issue;
        addr_d           = (hs || rd_issue) ? gen_addr : 32'h0;
        wdata_d          = hs ? s_data : '0;
        word_count_d     = word_count;
        checksum_d       = checksum;
        verify_acc_d     = verify_acc;
        sample_pending_d = 1'b0;
        err_code_d       = err_code;

        if ((next_state == ST_IDLE) || entering_load) begin
            word_count_d = '0;
            checksum_d   = '0;
            verify_acc_d = '0;
            err_code_d   = ERR_NONE;
        end else begin
            if (hs) begin
                word_count_d = word_count + CNT_W'(1);
                checksum_d   = checksum ^ s_data;
            end
            if (state == ST_VERIFY) begin
                sample_pending_d = ren_ext;
                if (sample_pending) verify_acc_d = verify_acc ^ rdata_ext;
            end
            if ((next_state == ST_ERROR) && (state == ST_LOAD))   err_code_d = ERR_OVF;
            if ((next_state == ST_ERROR) && (state == ST_VERIFY)) err_code_d = ERR_CSUM;
        end

        s_ready_d    = (next_state == ST_LOAD) && (word_count_d < DEPTH_CNT);
        cpu_enable_d = (next_state == ST_RUN);
        busy_d       = (next_state == ST_LOAD) || (next_state == ST_VERIFY);
        error_d      = (next_state == ST_ERROR);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_ready        <= 1'b0;
            addr_ext       <= 32'h0;
            wen_ext        <= 1'b0;
            ren_ext        <= 1'b0;
            wdata_ext      <= '0;
            cpu_enable     <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
            err_code       <= ERR_NONE;
            word_count     <= '0;
            checksum       <= '0;
            verify_acc     <= '0;
            sample_pending <= 1'b0;
        end else begin
            s_ready        <= s_ready_d;
            addr_ext       <= addr_d;
            wen_ext        <= wen_d;
            ren_ext        <= ren_d;
            wdata_ext      <= wdata_d;
            cpu_enable     <= cpu_enable_d;
            busy           <= busy_d;
            error          <= error_d;
            err_code       <= err_code_d;
            word_count     <= word_count_d;
            checksum       <= checksum_d;
            verify_acc     <= verify_acc_d;
            sample_pending <= sample_pending_d;
        end
    end

endmodule
